// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit of the multi-cycle MIPS datapath. A Moore FSM steps each
// instruction through fetch / decode / execute / memory / writeback and drives
// the unified instruction/data memory, the datapath mux selects, the register
// enables and the ALU control. The ALU decoder lives here as well.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high; forces FETCH
//   op          in   6  instr[31:26] from the instruction register
//   funct       in   6  instr[5:0] from the instruction register
//   zero        in   1  ALU zero flag
//   memwrite    out  1  memory write enable
//   iord        out  1  memory address select: 0 = PC, 1 = ALUOut
//   irwrite     out  1  instruction register load enable
//   pcen        out  1  PC load enable = pcwrite | (branch & zero)
//   regwrite    out  1  register file write enable
//   regdst      out  1  write register select: 0 = rt, 1 = rd
//   memtoreg    out  1  writeback select: 0 = ALUOut, 1 = data register
//   alusrca     out  1  ALU A select: 0 = PC, 1 = register A
//   alusrcb     out  2  ALU B select: 00 B, 01 4, 10 signimm, 11 signimm<<2
//   pcsrc       out  2  next PC select: 00 ALU result, 01 ALUOut, 10 jump
//   alucontrol  out  3  ALU operation
//   state       out  4  current FSM state (debug / verification)
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_FUNCT
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;

    // Next-state logic. Encodings 12-15 fall into the default and recover
    // to FETCH on the next edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case statement can infer a latch.
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;  // unsupported op: NOP
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Moore output decode: everything depends on state only, except pcen.
    logic   pcwrite, branch;
    logic   memwrite_raw, irwrite_raw, regwrite_raw;
    aluop_t aluop;

    always_comb begin
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALU_ADD;
        case (state_q)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;  // precompute branch target
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB:  regwrite_raw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH is the reset state and would otherwise assert irwrite/pcen, so all
    // write enables are gated off while reset is held.
    assign memwrite = memwrite_raw & ~reset;
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;

    // ALU decoder. Unknown funct codes default to add.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALU_ADD: alucontrol = 3'b010;
            ALU_SUB: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller: reset behaviour, a table of
// directed instructions with their expected state walks, an asynchronous reset
// in the middle of a load, and randomized instructions against a reference
// model built from instruction classes and per-state control tables.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    ctrl_t act;
    always_comb begin
        act            = '0;
        act.st         = state;
        act.memwrite   = memwrite;
        act.iord       = iord;
        act.irwrite    = irwrite;
        act.pcen       = pcen;
        act.regwrite   = regwrite;
        act.regdst     = regdst;
        act.memtoreg   = memtoreg;
        act.alusrca    = alusrca;
        act.alusrcb    = alusrcb;
        act.pcsrc      = pcsrc;
        act.alucontrol = alucontrol;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp, input logic [31:0] mask);
        n_checks++;
        if (((got ^ exp) & mask) == 32'd0) n_pass++;
        else $display("FAIL %s: got %h, expected %h (mask %h)", name, got & mask, exp & mask, mask);
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    // State walk for an instruction, from its class and cycle count.
    task automatic walk_of(input logic [5:0] o, output int n, output logic [19:0] sts);
        logic [3:0] q[$];
        q = {4'd0, 4'd1};
        case (o)
            6'b100011: q = {q, 4'd2, 4'd3, 4'd4};  // lw: 5 cycles
            6'b101011: q = {q, 4'd2, 4'd5};        // sw: 4
            6'b000000: q = {q, 4'd6, 4'd7};        // R-type: 4
            6'b001000: q = {q, 4'd9, 4'd10};       // addi: 4
            6'b000100: q = {q, 4'd8};              // beq: 3
            6'b000010: q = {q, 4'd11};             // j: 3
            default:   ;                           // unsupported: 2
        endcase
        n   = q.size();
        sts = '0;
        for (int i = 0; i < n; i++) sts[4*i +: 4] = q[i];
    endtask

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected controls in a given state; mask clears don't-care fields.
    task automatic model(input logic [3:0] st, input logic [5:0] f, input logic z,
                         output ctrl_t e, output ctrl_t m);
        e = '0;
        m = '1;
        m.regdst = 1'b0; m.memtoreg = 1'b0; m.pcsrc = '0; m.alucontrol = '0;
        e.st = st;
        case (st)
            4'd0:  begin e.alusrcb = 2'b01; e.alucontrol = 3'b010; m.alucontrol = '1;
                         m.pcsrc = '1; e.irwrite = 1'b1; e.pcen = 1'b1; end
            4'd1:  begin e.alusrcb = 2'b11; e.alucontrol = 3'b010; m.alucontrol = '1; end
            4'd2, 4'd9:
                   begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
                         m.alucontrol = '1; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            4'd6:  begin e.alusrca = 1'b1; e.alucontrol = funct_alu(f); m.alucontrol = '1; end
            4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1; end
            4'd8:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; m.alucontrol = '1;
                         e.pcsrc = 2'b01; m.pcsrc = '1; e.pcen = z; end
            4'd10: begin e.regwrite = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1; end
            4'd11: begin e.pcsrc = 2'b10; m.pcsrc = '1; e.pcen = 1'b1; end
            default: ;
        endcase
    endtask

    // Apply one instruction starting in FETCH; check state and controls on
    // each falling edge. Returns just after the edge that re-enters FETCH.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic z,
                             input int n, input logic [19:0] sts);
        ctrl_t e, m;
        logic [3:0] st_exp;
        op    = instr[31:26];
        funct = instr[5:0];
        zero  = z;
        for (int k = 0; k < n; k++) begin
            st_exp = sts[4*k +: 4];
            @(negedge clk);
            check($sformatf("%s step%0d state", name, k), 32'(state), 32'(st_exp), 32'hF);
            model(st_exp, funct, z, e, m);
            check($sformatf("%s step%0d ctrl", name, k), 32'(act), 32'(e), 32'(m));
            @(posedge clk);
            #1;
        end
    endtask

    // Directed table: instruction, zero, expected state count and walk.
    typedef struct packed {
        logic [31:0] instr;
        logic        z;
        logic [2:0]  n;
        logic [19:0] sts;
    } vec_t;

    vec_t  vecs [9];
    string names [9];

    ctrl_t e_rst, m_rst;

    initial begin
        vecs[0] = '{32'h20020005, 1'b0, 3'd4, 20'h0A910}; names[0] = "addi";
        vecs[1] = '{32'h00e22025, 1'b0, 3'd4, 20'h07610}; names[1] = "or";
        vecs[2] = '{32'h0064202a, 1'b1, 3'd4, 20'h07610}; names[2] = "slt";
        vecs[3] = '{32'h8c020050, 1'b0, 3'd5, 20'h43210}; names[3] = "lw";
        vecs[4] = '{32'hac670044, 1'b1, 3'd4, 20'h05210}; names[4] = "sw";
        vecs[5] = '{32'h10a7000a, 1'b1, 3'd3, 20'h00810}; names[5] = "beq_taken";
        vecs[6] = '{32'h10a7000a, 1'b0, 3'd3, 20'h00810}; names[6] = "beq_not_taken";
        vecs[7] = '{32'h08000011, 1'b0, 3'd3, 20'h00B10}; names[7] = "j";
        vecs[8] = '{32'hfc000000, 1'b1, 3'd2, 20'h00010}; names[8] = "op3f_nop";

        // Reset expectation: FETCH with every write enable low.
        e_rst = '0;
        m_rst = '0;
        m_rst.st = '1; m_rst.memwrite = 1'b1; m_rst.irwrite = 1'b1;
        m_rst.pcen = 1'b1; m_rst.regwrite = 1'b1;

        reset = 1'b1;
        op    = '0;
        funct = '0;
        zero  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset hold %0d", i), 32'(act), 32'(e_rst), 32'(m_rst));
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed instructions; first step covers the first fetch after reset.
        for (int i = 0; i < 9; i++)
            run_instr(names[i], vecs[i].instr, vecs[i].z, int'(vecs[i].n), vecs[i].sts);

        // Reset in MEMRD of a lw: FETCH immediately, no writeback.
        run_instr("lw_abort", 32'h8c020050, 1'b0, 3, 20'h00210);
        @(negedge clk);
        check("lw_abort in MEMRD", 32'(state), 32'd3, 32'hF);
        #1 reset = 1'b1;
        #1 check("lw_abort async", 32'(act), 32'(e_rst), 32'(m_rst));
        @(posedge clk);
        #1 check("lw_abort held", 32'(act), 32'(e_rst), 32'(m_rst));
        reset = 1'b0;
        run_instr("after_abort_addi", 32'h20020005, 1'b0, 4, 20'h0A910);

        // Randomized instructions against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [5:0]  r_op, r_funct;
            logic [31:0] word;
            logic [19:0] sts;
            int          n;
            case ($urandom_range(0, 7))
                0: r_op = 6'b100011;
                1: r_op = 6'b101011;
                2: r_op = 6'b000000;
                3: r_op = 6'b000000;
                4: r_op = 6'b000100;
                5: r_op = 6'b001000;
                6: r_op = 6'b000010;
                default: r_op = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 5))
                0: r_funct = 6'h20;
                1: r_funct = 6'h22;
                2: r_funct = 6'h24;
                3: r_funct = 6'h25;
                4: r_funct = 6'h2a;
                default: r_funct = 6'($urandom_range(0, 63));
            endcase
            word = {r_op, 20'($urandom), r_funct};
            walk_of(r_op, n, sts);
            run_instr($sformatf("rand%0d op%h f%h", i, r_op, r_funct), word,
                      1'($urandom_range(0, 1)), n, sts);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit of the multi-cycle MIPS datapath; sits directly upstream of the unified instruction/data memory.
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the memory write enable and the instruction/data address select (iord), plus all datapath mux selects, register enables and ALU control.
- Contains the ALU decoder.

Parameters:
- None. Supported opcodes and state encodings are fixed.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag
- memwrite  output  1  memory write enable (memory we)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  output  1  instruction register load enable
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- regwrite  output  1  register file write enable
- regdst  output  1  write register select: 0 = rt, 1 = rd
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = data register
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation
- state  output  4  current state, for debug/verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Values 12-15 are illegal and go to FETCH on the next edge.
- Reset: async assert sets state=FETCH immediately. While reset=1, memwrite, irwrite, pcen and regwrite are forced to 0. The first fetch happens on the first rising edge after reset deasserts. Reset mid-instruction aborts it with no further writes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (NOP, no writes).
  - MEMADR -> MEMRD if lw, MEMWR if sw.
  - MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3.
- Outputs are a function of state only, except pcen, which also uses zero. All unlisted outputs are 0; regdst, memtoreg and pcsrc are don't-care unless listed.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=add (precompute branch target).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memwrite=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=funct.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- ALU decoder (combinational):
  - add -> 010; sub -> 110.
  - funct decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010; writeback still occurs.
- Never assert memwrite and regwrite in the same cycle. irwrite is asserted only in FETCH.

Test Plan:
- Reset held 3 cycles, then released -> state=0 and all write enables 0 during reset; cycle 1 after release: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- IR=0x20020005 (addi) -> states 0,1,9,10,0; in state 10: regwrite=1, regdst=0, memtoreg=0.
- IR=0x00e22025 (or), then 0x0064202a (slt) -> states 0,1,6,7; alucontrol=001 in state 6 for or, 111 for slt; regdst=1 in state 7.
- IR=0x8c020050 (lw) -> states 0,1,2,3,4 (5 cycles), iord=1 in state 3, memtoreg=1 in state 4. IR=0xac670044 (sw) -> states 0,1,2,5, memwrite=1 only in state 5.
- IR=0x10a7000a (beq): in BEQEX with zero=1 -> pcen=1, pcsrc=01, alucontrol=110; with zero=0 -> pcen=0. IR=0x08000011 (j) -> JEX: pcen=1, pcsrc=10.
- IR op=111111 -> states 0,1,0 with no write enable asserted. Reset asserted in state 3 of a lw -> state=0 asynchronously (before the next edge), regwrite stays 0.
